// File: rtl/rvfi_monitor_rv32imc.sv
// Passive RVFI commit-stream checker for a single-retire RV32IMC core.
// Latches the code of the first self-consistency violation until reset.
module rvfi_monitor_rv32imc #(
    parameter int XLEN    = 32,
    parameter int ORDER_W = 64
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               rvfi_valid,
    input  logic [ORDER_W-1:0] rvfi_order,
    input  logic [31:0]        rvfi_insn,
    input  logic               rvfi_trap,
    input  logic               rvfi_halt,
    input  logic               rvfi_intr,
    input  logic [1:0]         rvfi_mode,
    input  logic [4:0]         rvfi_rs1_addr,
    input  logic [4:0]         rvfi_rs2_addr,
    input  logic [XLEN-1:0]    rvfi_rs1_rdata,
    input  logic [XLEN-1:0]    rvfi_rs2_rdata,
    input  logic [4:0]         rvfi_rd_addr,
    input  logic [XLEN-1:0]    rvfi_rd_wdata,
    input  logic [XLEN-1:0]    rvfi_pc_rdata,
    input  logic [XLEN-1:0]    rvfi_pc_wdata,
    input  logic [XLEN-1:0]    rvfi_mem_addr,
    input  logic [3:0]         rvfi_mem_rmask,
    input  logic [3:0]         rvfi_mem_wmask,
    input  logic [XLEN-1:0]    rvfi_mem_rdata,
    input  logic [XLEN-1:0]    rvfi_mem_wdata,
    input  logic               rvfi_mem_extamo,
    output logic [15:0]        errcode
);

    localparam logic [15:0] ERR_NONE   = 16'd0;
    localparam logic [15:0] ERR_ORDER  = 16'd1;
    localparam logic [15:0] ERR_PC     = 16'd2;
    localparam logic [15:0] ERR_ALIGN  = 16'd3;
    localparam logic [15:0] ERR_RS1    = 16'd4;
    localparam logic [15:0] ERR_RS2    = 16'd5;
    localparam logic [15:0] ERR_RD0    = 16'd6;
    localparam logic [15:0] ERR_RWMASK = 16'd7;
    localparam logic [15:0] ERR_MASK   = 16'd8;
    localparam logic [15:0] ERR_TRAP   = 16'd9;
    localparam logic [15:0] ERR_AMO    = 16'd10;

    logic [15:0]        err_q, err_d;
    logic [ORDER_W-1:0] exp_order_q, exp_order_d;
    logic               first_q, first_d;
    logic [XLEN-1:0]    last_pc_q, last_pc_d;
    logic [XLEN-1:0]    shadow_q [32];
    logic [XLEN-1:0]    shadow_d [32];
    logic [31:0]        shadow_vld_q, shadow_vld_d;

    logic        order_bad, pc_bad, align_bad, rs1_bad, rs2_bad, rd0_bad;
    logic        rw_bad, mask_bad;
    logic [15:0] code;

    // Legal byte-lane patterns: any single byte, aligned halves, or full word.
    function automatic logic mask_ok(input logic [3:0] m);
        logic ok;
        case (m)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
            4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
            default:                   ok = 1'b0;
        endcase
        return ok;
    endfunction

    always_comb begin
        order_bad = (rvfi_order != exp_order_q);
        pc_bad    = !first_q && (rvfi_pc_rdata != last_pc_q);
        align_bad = rvfi_pc_rdata[0] || rvfi_pc_wdata[0];
        // x0 must read zero; other registers compare against the last value written.
        rs1_bad   = (rvfi_rs1_addr == 5'd0) ? (rvfi_rs1_rdata != '0)
                  : (shadow_vld_q[rvfi_rs1_addr] && (shadow_q[rvfi_rs1_addr] != rvfi_rs1_rdata));
        rs2_bad   = (rvfi_rs2_addr == 5'd0) ? (rvfi_rs2_rdata != '0)
                  : (shadow_vld_q[rvfi_rs2_addr] && (shadow_q[rvfi_rs2_addr] != rvfi_rs2_rdata));
        rd0_bad   = (rvfi_rd_addr == 5'd0) && (rvfi_rd_wdata != '0);
        rw_bad    = (rvfi_mem_rmask != 4'd0) && (rvfi_mem_wmask != 4'd0);
        mask_bad  = !mask_ok(rvfi_mem_rmask) || !mask_ok(rvfi_mem_wmask);
    end

    always_comb begin
        code = ERR_NONE;
        if (order_bad)            code = ERR_ORDER;
        else if (pc_bad)          code = ERR_PC;
        else if (align_bad)       code = ERR_ALIGN;
        else if (rs1_bad)         code = ERR_RS1;
        else if (rs2_bad)         code = ERR_RS2;
        else if (rd0_bad)         code = ERR_RD0;
        else if (rw_bad)          code = ERR_RWMASK;
        else if (mask_bad)        code = ERR_MASK;
        else if (rvfi_trap)       code = ERR_TRAP;
        else if (rvfi_mem_extamo) code = ERR_AMO;
    end

    // Tracking follows every commit, even faulty ones, so one bad commit
    // does not cascade into spurious order/PC errors on later ones.
    always_comb begin
        err_d        = err_q;
        exp_order_d  = exp_order_q;
        first_d      = first_q;
        last_pc_d    = last_pc_q;
        shadow_d     = shadow_q;
        shadow_vld_d = shadow_vld_q;
        if (rvfi_valid) begin
            if (err_q == ERR_NONE) begin
                err_d = code;
            end
            exp_order_d = rvfi_order + 1'b1;
            last_pc_d   = rvfi_pc_wdata;
            first_d     = 1'b0;
            if (rvfi_rd_addr != 5'd0) begin
                shadow_d[rvfi_rd_addr]     = rvfi_rd_wdata;
                shadow_vld_d[rvfi_rd_addr] = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            err_q        <= ERR_NONE;
            exp_order_q  <= '0;
            first_q      <= 1'b1;
            last_pc_q    <= '0;
            shadow_vld_q <= '0;
        end else begin
            err_q        <= err_d;
            exp_order_q  <= exp_order_d;
            first_q      <= first_d;
            last_pc_q    <= last_pc_d;
            shadow_vld_q <= shadow_vld_d;
        end
    end

    // Shadow data is qualified by shadow_vld_q, so it needs no reset.
    always_ff @(posedge clock) begin
        shadow_q <= shadow_d;
    end

    assign errcode = err_q;

    logic unused_inputs;
    assign unused_inputs = ^{rvfi_insn, rvfi_halt, rvfi_intr, rvfi_mode,
                             rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata};

endmodule

// File: tb/tb_rvfi_monitor_rv32imc.sv
// Bench for rvfi_monitor_rv32imc: directed scenarios plus randomized commit
// streams with injected faults, scored against a rule-level reference model.
module tb_rvfi_monitor_rv32imc;

    logic        clk;
    logic        reset;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic [31:0] rvfi_insn;
    logic        rvfi_trap;
    logic        rvfi_halt;
    logic        rvfi_intr;
    logic [1:0]  rvfi_mode;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata;
    logic [31:0] rvfi_mem_addr, rvfi_mem_rdata, rvfi_mem_wdata;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;
    logic        rvfi_mem_extamo;
    logic [15:0] errcode;

    rvfi_monitor_rv32imc #(.XLEN(32), .ORDER_W(64)) dut (
        .clock(clk), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_insn(rvfi_insn), .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt),
        .rvfi_intr(rvfi_intr), .rvfi_mode(rvfi_mode),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask),
        .rvfi_mem_wmask(rvfi_mem_wmask), .rvfi_mem_rdata(rvfi_mem_rdata),
        .rvfi_mem_wdata(rvfi_mem_wdata), .rvfi_mem_extamo(rvfi_mem_extamo),
        .errcode(errcode)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- reference model ----------------
    logic [31:0] m_regs  [32];
    bit          m_known [32];
    logic [15:0] m_err;
    logic [63:0] m_order;
    bit          m_first;
    logic [31:0] m_pc;
    logic [3:0]  legal_masks [7] = '{4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};

    logic [15:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: errcode=%0d expected=%0d at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_err   = 16'd0;
        m_order = 64'd0;
        m_first = 1'b1;
        m_pc    = 32'd0;
        for (int i = 0; i < 32; i++) begin
            m_known[i] = 1'b0;
            m_regs[i]  = 32'd0;
        end
    endtask

    function automatic bit src_wrong(input logic [4:0] a, input logic [31:0] d);
        if (a == 5'd0) return d != 32'd0;
        return m_known[a] && (m_regs[a] != d);
    endfunction

    function automatic bit mask_legal(input logic [3:0] m);
        return (m == 4'h0) || (m inside {4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF});
    endfunction

    task automatic model_commit(input logic [63:0] ord, input logic [31:0] pcr, pcw,
                                input logic [4:0] r1a, input logic [31:0] r1d,
                                input logic [4:0] r2a, input logic [31:0] r2d,
                                input logic [4:0] rda, input logic [31:0] rdd,
                                input logic [3:0] rm, wm, input logic trap, amo);
        bit [10:1] viol;
        logic [15:0] code;
        viol[1]  = (ord != m_order);
        viol[2]  = !m_first && (pcr != m_pc);
        viol[3]  = pcr[0] || pcw[0];
        viol[4]  = src_wrong(r1a, r1d);
        viol[5]  = src_wrong(r2a, r2d);
        viol[6]  = (rda == 5'd0) && (rdd != 32'd0);
        viol[7]  = (rm != 4'h0) && (wm != 4'h0);
        viol[8]  = !mask_legal(rm) || !mask_legal(wm);
        viol[9]  = trap;
        viol[10] = amo;
        code = 16'd0;
        for (int k = 10; k >= 1; k--) if (viol[k]) code = 16'(k);
        if (m_err == 16'd0) m_err = code;
        m_order = ord + 64'd1;
        m_pc    = pcw;
        m_first = 1'b0;
        if (rda != 5'd0) begin
            m_regs[rda]  = rdd;
            m_known[rda] = 1'b1;
        end
        exp_q.push_back(m_err);
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_junk(input logic v);
        rvfi_valid      = v;
        rvfi_order      = {$urandom(), $urandom()};
        rvfi_insn       = $urandom();
        rvfi_trap       = 1'($urandom_range(0, 1));
        rvfi_halt       = 1'($urandom_range(0, 1));
        rvfi_intr       = 1'($urandom_range(0, 1));
        rvfi_mode       = 2'($urandom_range(0, 3));
        rvfi_rs1_addr   = 5'($urandom_range(0, 31));
        rvfi_rs2_addr   = 5'($urandom_range(0, 31));
        rvfi_rs1_rdata  = $urandom();
        rvfi_rs2_rdata  = $urandom();
        rvfi_rd_addr    = 5'($urandom_range(0, 31));
        rvfi_rd_wdata   = $urandom();
        rvfi_pc_rdata   = $urandom();
        rvfi_pc_wdata   = $urandom();
        rvfi_mem_addr   = $urandom();
        rvfi_mem_rmask  = 4'($urandom_range(0, 15));
        rvfi_mem_wmask  = 4'($urandom_range(0, 15));
        rvfi_mem_rdata  = $urandom();
        rvfi_mem_wdata  = $urandom();
        rvfi_mem_extamo = 1'($urandom_range(0, 1));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive_junk(1'b1);
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("reset", errcode, 16'd0);
        @(negedge clk);
        reset = 1'b1;
        rvfi_valid = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        drive_junk(1'b0);
        exp_q.push_back(m_err);
        @(posedge clk);
        #1;
        check("idle", errcode, exp_q.pop_front());
    endtask

    task automatic commit(input logic [63:0] ord, input logic [31:0] pcr, pcw,
                          input logic [4:0] r1a, input logic [31:0] r1d,
                          input logic [4:0] r2a, input logic [31:0] r2d,
                          input logic [4:0] rda, input logic [31:0] rdd,
                          input logic [3:0] rm, wm, input logic trap, amo);
        @(negedge clk);
        drive_junk(1'b1);
        rvfi_order = ord;          rvfi_pc_rdata = pcr;       rvfi_pc_wdata = pcw;
        rvfi_rs1_addr = r1a;       rvfi_rs1_rdata = r1d;
        rvfi_rs2_addr = r2a;       rvfi_rs2_rdata = r2d;
        rvfi_rd_addr = rda;        rvfi_rd_wdata = rdd;
        rvfi_mem_rmask = rm;       rvfi_mem_wmask = wm;
        rvfi_trap = trap;          rvfi_mem_extamo = amo;
        model_commit(ord, pcr, pcw, r1a, r1d, r2a, r2d, rda, rdd, rm, wm, trap, amo);
        @(posedge clk);
        #1;
        check("commit", errcode, exp_q.pop_front());
    endtask

    // Clean commit that continues from model state, optionally with one fault.
    task automatic rand_commit(input int fault);
        logic [63:0] ord;
        logic [31:0] pcr, pcw, r1d, r2d, rdd, junk;
        logic [4:0]  r1a, r2a, rda;
        logic [3:0]  rm, wm;
        logic        trap, amo;
        int          kind;
        ord  = m_order;
        junk = $urandom();
        pcr  = m_first ? (junk & 32'hFFFF_FFFE) : m_pc;
        kind = $urandom_range(0, 3);
        junk = $urandom();
        pcw  = (kind == 0) ? (junk & 32'hFFFF_FFFE) : (kind == 1) ? pcr + 32'd2 : pcr + 32'd4;
        r1a  = 5'($urandom_range(0, 31));
        r2a  = 5'($urandom_range(0, 31));
        r1d  = (r1a == 5'd0) ? 32'd0 : (m_known[r1a] ? m_regs[r1a] : $urandom());
        r2d  = (r2a == 5'd0) ? 32'd0 : (m_known[r2a] ? m_regs[r2a] : $urandom());
        rda  = 5'($urandom_range(0, 31));
        rdd  = (rda == 5'd0) ? 32'd0 : $urandom();
        kind = $urandom_range(0, 2);
        rm   = (kind == 1) ? legal_masks[$urandom_range(0, 6)] : 4'h0;
        wm   = (kind == 2) ? legal_masks[$urandom_range(0, 6)] : 4'h0;
        trap = 1'b0;
        amo  = 1'b0;
        case (fault)
            0: ord = ord + 64'($urandom_range(1, 1000));
            1: pcr = pcr ^ 32'h0000_0010;
            2: if ($urandom_range(0, 1) == 1) pcr = pcr | 32'd1; else pcw = pcw | 32'd1;
            3: r1d = r1d ^ ($urandom() | 32'd1);
            4: r2d = r2d ^ ($urandom() | 32'd1);
            5: begin rda = 5'd0; rdd = $urandom() | 32'd1; end
            6: begin rm = legal_masks[$urandom_range(0, 6)]; wm = legal_masks[$urandom_range(0, 6)]; end
            7: begin rm = 4'($urandom_range(1, 15)); wm = 4'h0; end
            8: trap = 1'b1;
            9: amo = 1'b1;
            default: ;
        endcase
        commit(ord, pcr, pcw, r1a, r1d, r2a, r2d, rda, rdd, rm, wm, trap, amo);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset = 1'b0;
        drive_junk(1'b0);
        model_reset();

        // Register chaining through a compressed instruction at 0x4.
        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 5'd1, 32'd5, 4'h0, 4'h0, 0, 0);
        commit(1, 32'h4, 32'h6, 5'd1, 32'd5, 0, 0, 5'd0, 32'd0, 4'h1, 4'h0, 0, 0);
        commit(2, 32'h6, 32'h8, 5'd1, 32'd5, 5'd1, 32'd5, 5'd1, 32'd9, 4'h0, 4'hF, 0, 0);
        check("plan1_clean", errcode, 16'd0);

        // Order gap, then sticky despite a later PC break.
        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        commit(1, 32'h4, 32'h8, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        commit(3, 32'h8, 32'hC, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        check("plan2_order", errcode, 16'd1);
        commit(4, 32'h40, 32'h44, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        check("plan2_sticky", errcode, 16'd1);

        do_reset();
        commit(0, 32'h0, 32'h100, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        commit(1, 32'h104, 32'h108, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        check("plan3_pc", errcode, 16'd2);
        do_reset();
        commit(0, 32'h101, 32'h104, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        check("plan3_align", errcode, 16'd3);

        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 5'd5, 32'hDEADBEEF, 4'h0, 4'h0, 0, 0);
        commit(1, 32'h4, 32'h8, 0, 0, 5'd5, 32'd0, 0, 0, 4'h0, 4'h0, 0, 0);
        check("plan4_rs2", errcode, 16'd5);
        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 5'd0, 32'd1, 4'h0, 4'h0, 0, 0);
        check("plan4_rd0", errcode, 16'd6);

        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 4'h5, 4'h0, 0, 0);
        check("plan5_mask", errcode, 16'd8);
        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 4'h1, 4'h1, 0, 0);
        check("plan5_rw", errcode, 16'd7);

        // Same-cycle rd write must not affect this commit's rs check.
        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 5'd3, 32'd11, 4'h0, 4'h0, 0, 0);
        commit(1, 32'h4, 32'h8, 5'd3, 32'd11, 0, 0, 5'd3, 32'd22, 4'h0, 4'h0, 0, 0);
        commit(2, 32'h8, 32'hA, 5'd3, 32'd22, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        check("same_cycle", errcode, 16'd0);
        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 1, 0);
        check("trap", errcode, 16'd9);
        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 0, 0, 4'h0, 4'h0, 0, 1);
        check("extamo", errcode, 16'd10);

        // Reset clears a latched error; restart needs no PC continuity.
        do_reset();
        commit(0, 32'h0, 32'h4, 0, 0, 0, 0, 5'd2, 32'd7, 4'h0, 4'h0, 0, 0);
        commit(1, 32'h4, 32'h8, 5'd2, 32'd8, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        check("plan6_rs1", errcode, 16'd4);
        do_reset();
        check("plan6_cleared", errcode, 16'd0);
        commit(0, 32'h1234, 32'h1238, 5'd2, 32'd99, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0);
        check("plan6_restart", errcode, 16'd0);

        // Randomized episodes with occasional single faults and idle cycles.
        for (int ep = 0; ep < 60; ep++) begin
            int n;
            do_reset();
            n = $urandom_range(4, 14);
            for (int c = 0; c < n; c++) begin
                if ($urandom_range(0, 4) == 0) idle();
                if ($urandom_range(0, 5) == 0) rand_commit($urandom_range(0, 9));
                else rand_commit(-1);
            end
        end

        @(negedge clk);
        rvfi_valid = 1'b0;
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
